// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: per-stage bundle widths, control bundle layouts
// and small helpers used by the stage register.
package cpu_pipe_pkg;

    localparam int unsigned OCC_W = 2;

    // Control bundles; instances cast these to and from CTRL_W vectors.
    typedef struct packed {
        logic pred_taken;
        logic fetch_fault;
    } ifid_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [4:0] rd;
    } idex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch_taken;
        logic [2:0] mem_size;
        logic [4:0] rd;
    } exmem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } memwb_ctrl_t;

    localparam int unsigned IFID_DATA_W  = 96;
    localparam int unsigned IDEX_DATA_W  = 256;
    localparam int unsigned EXMEM_DATA_W = 192;
    localparam int unsigned MEMWB_DATA_W = 64;

    localparam int unsigned IFID_CTRL_W  = $bits(ifid_ctrl_t);
    localparam int unsigned IDEX_CTRL_W  = $bits(idex_ctrl_t);
    localparam int unsigned EXMEM_CTRL_W = $bits(exmem_ctrl_t);
    localparam int unsigned MEMWB_CTRL_W = $bits(memwb_ctrl_t);

    function automatic logic [OCC_W-1:0] occ_count(input logic a, input logic b);
        return OCC_W'(a) + OCC_W'(b);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake carrying one data bundle and one control bundle.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One valid/data/ctrl holding register with clear, load and hold.
// A cleared slot always holds zero data and control.
module pipe_slot #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// and an optional skid entry that registers the upstream ready.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned SKID   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_reg_if.slave     up,
    pipe_stage_reg_if.master    dn,
    output logic [OCC_W-1:0]    occupancy
);

    logic              in_fire;
    logic              out_fire;
    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic [CTRL_W-1:0] main_c;
    logic              main_load;
    logic              main_clr;
    logic [DATA_W-1:0] main_nd;
    logic [CTRL_W-1:0] main_nc;
    logic              main_v_nxt;
    logic              skid_v_nxt;

    assign in_fire  = up.valid & up.ready;
    assign out_fire = main_v & dn.ready;

    assign dn.valid = main_v;
    assign dn.data  = main_d;
    assign dn.ctrl  = main_c;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush | main_clr),
        .load   (main_load),
        .d_data (main_nd),
        .d_ctrl (main_nc),
        .valid  (main_v),
        .data   (main_d),
        .ctrl   (main_c)
    );

    assign main_v_nxt = main_load | (main_v & ~main_clr);

    if (SKID != 0) begin : g_skid
        logic              skid_v;
        logic [DATA_W-1:0] skid_d;
        logic [CTRL_W-1:0] skid_c;
        logic              skid_load;
        logic              skid_clr;

        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clk    (clk),
            .reset  (reset),
            .clear  (flush | skid_clr),
            .load   (skid_load),
            .d_data (up.data),
            .d_ctrl (up.ctrl),
            .valid  (skid_v),
            .data   (skid_d),
            .ctrl   (skid_c)
        );

        // Ready depends only on held state, never on downstream ready.
        assign up.ready  = ~reset & ~skid_v;
        assign skid_v_nxt = skid_load | (skid_v & ~skid_clr);

        // Main refills from skid first to keep FIFO order.
        always_comb begin
            main_load = 1'b0;
            main_clr  = 1'b0;
            main_nd   = up.data;
            main_nc   = up.ctrl;
            skid_load = 1'b0;
            skid_clr  = 1'b0;
            if (!main_v || out_fire) begin
                if (skid_v) begin
                    main_load = 1'b1;
                    main_nd   = skid_d;
                    main_nc   = skid_c;
                    skid_load = in_fire;
                    skid_clr  = ~in_fire;
                end else if (in_fire) begin
                    main_load = 1'b1;
                end else begin
                    main_clr  = 1'b1;
                end
            end else if (in_fire) begin
                skid_load = 1'b1;
            end
        end
    end else begin : g_noskid
        assign up.ready   = ~reset & (~main_v | dn.ready);
        assign skid_v_nxt = 1'b0;

        always_comb begin
            main_load = in_fire;
            main_clr  = ~in_fire & out_fire;
            main_nd   = up.data;
            main_nc   = up.ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_count(main_v_nxt, skid_v_nxt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances side by side, checked
// against directed tables and a FIFO reference model under random traffic.
module tb_pipe_stage_reg;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occ1;
    logic [1:0] occ0;

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) up1 ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) dn1 ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) up0 ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(16)) dn0 ();

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .up(up1), .dn(dn1), .occupancy(occ1)
    );
    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .up(up0), .dn(dn0), .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        rdy;
        logic        v;
        logic [63:0] q;
        logic [1:0]  occ;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [63:0] q1[$];
    logic [63:0] q0[$];

    logic        s_rst, s_fl, s_iv1, s_or1, s_iv0, s_or0;
    logic [63:0] s_d1, s_d0;
    logic        e_rdy1, e_rdy0;

    vec_t tab1[25];
    vec_t tab0[8];

    function automatic logic [15:0] cf(input logic [63:0] d);
        return 16'(d) ^ 16'hA5C3;
    endfunction

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [63:0] d, input logic ordy, input logic rdy,
                                input logic v, input logic [63:0] q, input logic [1:0] occ);
        vec_t r;
        r.rst = rst; r.fl = fl; r.iv = iv; r.d = d; r.ordy = ordy;
        r.rdy = rdy; r.v = v; r.q = q; r.occ = occ;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl,
                         input logic iv1, input logic [63:0] d1, input logic or1,
                         input logic iv0, input logic [63:0] d0, input logic or0);
        @(negedge clk);
        reset = rst; flush = fl;
        up1.valid = iv1; up1.data = d1; up1.ctrl = cf(d1); dn1.ready = or1;
        up0.valid = iv0; up0.data = d0; up0.ctrl = cf(d0); dn0.ready = or0;
        s_rst = rst; s_fl = fl;
        s_iv1 = iv1; s_d1 = d1; s_or1 = or1;
        s_iv0 = iv0; s_d0 = d0; s_or0 = or0;
        #1;
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1 (no skid), head shown downstream.
    task automatic check_model();
        logic [63:0] h1, h0;
        e_rdy1 = !s_rst && (q1.size() < 2);
        e_rdy0 = !s_rst && (q0.size() == 0 || s_or0);
        h1 = (q1.size() != 0) ? q1[0] : 64'd0;
        h0 = (q0.size() != 0) ? q0[0] : 64'd0;
        chk("s1_ready", 64'(up1.ready), 64'(e_rdy1));
        chk("s1_valid", 64'(dn1.valid), 64'(q1.size() != 0));
        chk("s1_data",  dn1.data, h1);
        chk("s1_ctrl",  64'(dn1.ctrl), (q1.size() != 0) ? 64'(cf(h1)) : 64'd0);
        chk("s1_occ",   64'(occ1), 64'(q1.size()));
        chk("s0_ready", 64'(up0.ready), 64'(e_rdy0));
        chk("s0_valid", 64'(dn0.valid), 64'(q0.size() != 0));
        chk("s0_data",  dn0.data, h0);
        chk("s0_ctrl",  64'(dn0.ctrl), (q0.size() != 0) ? 64'(cf(h0)) : 64'd0);
        chk("s0_occ",   64'(occ0), 64'(q0.size()));
    endtask

    task automatic advance();
        @(posedge clk);
        if (s_rst || s_fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (q1.size() > 0 && s_or1) void'(q1.pop_front());
            if (s_iv1 && e_rdy1) q1.push_back(s_d1);
            if (q0.size() > 0 && s_or0) void'(q0.pop_front());
            if (s_iv0 && e_rdy0) q0.push_back(s_d0);
        end
    endtask

    task automatic check_vec(input bit sk, input int idx, input vec_t v);
        string p;
        p = sk ? $sformatf("tab1[%0d]", idx) : $sformatf("tab0[%0d]", idx);
        if (sk) begin
            chk({p, "_ready"}, 64'(up1.ready), 64'(v.rdy));
            chk({p, "_valid"}, 64'(dn1.valid), 64'(v.v));
            chk({p, "_data"},  dn1.data, v.q);
            chk({p, "_ctrl"},  64'(dn1.ctrl), v.v ? 64'(cf(v.q)) : 64'd0);
            chk({p, "_occ"},   64'(occ1), 64'(v.occ));
        end else begin
            chk({p, "_ready"}, 64'(up0.ready), 64'(v.rdy));
            chk({p, "_valid"}, 64'(dn0.valid), 64'(v.v));
            chk({p, "_data"},  dn0.data, v.q);
            chk({p, "_ctrl"},  64'(dn0.ctrl), v.v ? 64'(cf(v.q)) : 64'd0);
            chk({p, "_occ"},   64'(occ0), 64'(v.occ));
        end
    endtask

    initial begin
        // SKID=1: reset, streaming, stall, flush, reset while full.
        tab1[0]  = mk(1, 0, 1, 64'hDEAD, 1, 0, 0, 64'h0,  2'd0);
        tab1[1]  = mk(1, 0, 1, 64'hDEAD, 1, 0, 0, 64'h0,  2'd0);
        tab1[2]  = mk(0, 0, 0, 64'h0,    1, 1, 0, 64'h0,  2'd0);
        tab1[3]  = mk(0, 0, 1, 64'h01,   1, 1, 0, 64'h0,  2'd0);
        tab1[4]  = mk(0, 0, 1, 64'h02,   1, 1, 1, 64'h01, 2'd1);
        tab1[5]  = mk(0, 0, 1, 64'h03,   1, 1, 1, 64'h02, 2'd1);
        tab1[6]  = mk(0, 0, 0, 64'h0,    1, 1, 1, 64'h03, 2'd1);
        tab1[7]  = mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h0,  2'd0);
        tab1[8]  = mk(0, 0, 1, 64'hA1,   0, 1, 0, 64'h0,  2'd0);
        tab1[9]  = mk(0, 0, 1, 64'hA2,   0, 1, 1, 64'hA1, 2'd1);
        tab1[10] = mk(0, 0, 1, 64'hA3,   0, 0, 1, 64'hA1, 2'd2);
        tab1[11] = mk(0, 0, 1, 64'hA3,   1, 0, 1, 64'hA1, 2'd2);
        tab1[12] = mk(0, 0, 1, 64'hA3,   1, 1, 1, 64'hA2, 2'd1);
        tab1[13] = mk(0, 0, 0, 64'h0,    1, 1, 1, 64'hA3, 2'd1);
        tab1[14] = mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h0,  2'd0);
        tab1[15] = mk(0, 0, 1, 64'hC1,   0, 1, 0, 64'h0,  2'd0);
        tab1[16] = mk(0, 0, 1, 64'hC2,   0, 1, 1, 64'hC1, 2'd1);
        tab1[17] = mk(0, 1, 1, 64'hB0,   0, 0, 1, 64'hC1, 2'd2);
        tab1[18] = mk(0, 1, 1, 64'hB1,   0, 1, 0, 64'h0,  2'd0);
        tab1[19] = mk(0, 0, 0, 64'h0,    1, 1, 0, 64'h0,  2'd0);
        tab1[20] = mk(0, 0, 1, 64'hD1,   0, 1, 0, 64'h0,  2'd0);
        tab1[21] = mk(0, 0, 1, 64'hD2,   0, 1, 1, 64'hD1, 2'd1);
        tab1[22] = mk(1, 0, 1, 64'hD3,   0, 0, 1, 64'hD1, 2'd2);
        tab1[23] = mk(0, 0, 0, 64'h0,    1, 1, 0, 64'h0,  2'd0);
        tab1[24] = mk(0, 0, 0, 64'h0,    1, 1, 0, 64'h0,  2'd0);
        // SKID=0: combinational stall/release, flush with a live accept.
        tab0[0]  = mk(0, 0, 1, 64'hE1,   0, 1, 0, 64'h0,  2'd0);
        tab0[1]  = mk(0, 0, 1, 64'hE2,   0, 0, 1, 64'hE1, 2'd1);
        tab0[2]  = mk(0, 0, 1, 64'hE2,   1, 1, 1, 64'hE1, 2'd1);
        tab0[3]  = mk(0, 0, 0, 64'h0,    1, 1, 1, 64'hE2, 2'd1);
        tab0[4]  = mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h0,  2'd0);
        tab0[5]  = mk(0, 0, 1, 64'hE3,   1, 1, 0, 64'h0,  2'd0);
        tab0[6]  = mk(0, 1, 1, 64'hE4,   1, 1, 1, 64'hE3, 2'd1);
        tab0[7]  = mk(0, 0, 0, 64'h0,    1, 1, 0, 64'h0,  2'd0);

        reset = 1'b1; flush = 1'b0;
        up1.valid = 1'b0; up1.data = '0; up1.ctrl = '0; dn1.ready = 1'b1;
        up0.valid = 1'b0; up0.data = '0; up0.ctrl = '0; dn0.ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tab1[i]) begin
            drive(tab1[i].rst, tab1[i].fl, tab1[i].iv, tab1[i].d, tab1[i].ordy, 1'b0, 64'd0, 1'b1);
            check_model();
            check_vec(1'b1, i, tab1[i]);
            advance();
        end

        foreach (tab0[i]) begin
            drive(tab0[i].rst, tab0[i].fl, 1'b0, 64'd0, 1'b1, tab0[i].iv, tab0[i].d, tab0[i].ordy);
            check_model();
            check_vec(1'b0, i, tab0[i]);
            advance();
        end

        // Back-to-back streaming of 8'h01..8'h08 into both variants.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 64'(i), 1'b1, 1'b1, 64'(i), 1'b1);
            check_model();
            chk("stream_occ_lt2", 64'(occ1 == 2'd2), 64'd0);
            advance();
        end
        repeat (2) begin
            drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
            check_model();
            advance();
        end

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 600; n++) begin
            logic rr, ff;
            rr = ($urandom_range(63) == 0);
            ff = ($urandom_range(31) == 0);
            drive(rr, ff,
                  1'($urandom_range(1)), {$urandom, $urandom}, ($urandom_range(3) != 0),
                  1'($urandom_range(1)), {$urandom, $urandom}, ($urandom_range(3) != 0));
            check_model();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
